// File: rtl/tick_to_level_fsm.sv
// Converts single-cycle ticks into fixed-width level pulses separated by a minimum gap.
// Ticks arriving mid-pulse are queued in a saturating counter; overflow raises a one-cycle dropped flag.
module tick_to_level_fsm #(
    parameter int HIGH_CYCLES = 2,
    parameter int GAP_CYCLES  = 1,
    parameter int PEND_MAX    = 3,
    localparam int PW         = $clog2(PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    output logic          level,
    output logic [1:0]    state_o,
    output logic          busy,
    output logic [PW-1:0] pending_o,
    output logic          dropped
);

    localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PEND_LIM  = PW'(PEND_MAX);
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2,
        S_ILL  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          dropped_q, dropped_d;
    logic          take_queue;
    logic          take_tick;
    logic          enqueue;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    // A pulse start prefers a queued tick over the incoming one.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        take_queue = 1'b0;
        take_tick  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d    = S_HIGH;
                    cnt_d      = HIGH_LOAD;
                    take_queue = 1'b1;
                end else if (tick) begin
                    state_d   = S_HIGH;
                    cnt_d     = HIGH_LOAD;
                    take_tick = 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (pending_q != '0) begin
                    state_d    = S_HIGH;
                    cnt_d      = HIGH_LOAD;
                    take_queue = 1'b1;
                end else if (tick) begin
                    state_d   = S_HIGH;
                    cnt_d     = HIGH_LOAD;
                    take_tick = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Simultaneous consume and enqueue leaves the count unchanged, so a full queue only drops when nothing leaves.
    always_comb begin
        enqueue   = tick && !take_tick;
        pending_d = pending_q;
        dropped_d = 1'b0;
        if (enqueue && !take_queue) begin
            if (pending_q == PEND_LIM) begin
                dropped_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (!enqueue && take_queue) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    assign level     = (state_q == S_HIGH);
    assign state_o   = state_q;
    assign busy      = (state_q != S_IDLE) || (pending_q != '0);
    assign pending_o = pending_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_tick_to_level_fsm.sv
// Bench for tick_to_level_fsm: vector table, hand-written reset sequence,
// and random ticks against a timestamp-based pulse scheduler model.
module tb_tick_to_level_fsm;

    localparam int H    = 2;
    localparam int G    = 1;
    localparam int PMAX = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       level;
    logic [1:0] state_o;
    logic       busy;
    logic [1:0] pending_o;
    logic       dropped;

    int errors = 0;
    int checks = 0;

    tick_to_level_fsm #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_MAX   (PMAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .level    (level),
        .state_o  (state_o),
        .busy     (busy),
        .pending_o(pending_o),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tk;
        logic       lvl;
        logic [1:0] st;
        logic [1:0] pend;
        logic       drp;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic t, input logic l, input logic [1:0] s,
                                input logic [1:0] p, input logic d, input logic b);
        vec_t v;
        v.rst = r; v.tk = t; v.lvl = l; v.st = s; v.pend = p; v.drp = d; v.bsy = b;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic t);
        reset = r;
        tick  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int idx, input logic l, input logic [1:0] s,
                           input logic [1:0] p, input logic d, input logic b);
        checks++;
        if (level !== l || state_o !== s || pending_o !== p || dropped !== d || busy !== b) begin
            errors++;
            $display("FAIL %s[%0d]: got lvl=%b st=%0d pend=%0d drp=%b busy=%b, expected lvl=%b st=%0d pend=%0d drp=%b busy=%b",
                     nm, idx, level, state_o, pending_o, dropped, busy, l, s, p, d, b);
        end
    endtask

    // Reference model: remembers the last pulse start edge and the earliest edge a new one may start.
    int m_cyc, m_start, m_next_free, m_pend, m_drops, m_ticks;
    logic       m_lvl, m_drp, m_bsy;
    logic [1:0] m_st;

    function automatic void model_reset();
        m_cyc = 0; m_start = -1000; m_next_free = 0; m_pend = 0;
        m_drops = 0; m_ticks = 0; m_drp = 1'b0;
    endfunction

    function automatic void model_step(input logic t);
        bit consumed_tick = 0;
        int age;
        m_drp = 1'b0;
        if (t) m_ticks++;
        if (m_cyc >= m_next_free && (m_pend > 0 || t)) begin
            m_start     = m_cyc;
            m_next_free = m_cyc + H + G;
            if (m_pend > 0) m_pend--;
            else consumed_tick = 1;
        end
        if (t && !consumed_tick) begin
            if (m_pend == PMAX) begin
                m_drp = 1'b1;
                m_drops++;
            end else begin
                m_pend++;
            end
        end
        age   = m_cyc - m_start;
        m_lvl = (age < H);
        m_st  = (age < H) ? 2'd1 : (age < H + G) ? 2'd2 : 2'd0;
        m_bsy = (m_st != 2'd0) || (m_pend != 0);
        m_cyc++;
    endfunction

    initial begin
        int rises;
        int dut_drops;
        logic prev_lvl;

        // reset held with tick high, then release
        add(1,1,0,0,0,0,0); add(1,1,0,0,0,0,0);
        add(0,0,0,0,0,0,0); add(0,0,0,0,0,0,0);
        // single tick
        add(0,1,1,1,0,0,1); add(0,0,1,1,0,0,1); add(0,0,0,2,0,0,1); add(0,0,0,0,0,0,0);
        // second tick lands exactly at gap end
        add(0,1,1,1,0,0,1); add(0,0,1,1,0,0,1); add(0,0,0,2,0,0,1);
        add(0,1,1,1,0,0,1); add(0,0,1,1,0,0,1); add(0,0,0,2,0,0,1); add(0,0,0,0,0,0,0);
        // six back-to-back ticks: queue saturates, one drop
        add(0,1,1,1,0,0,1); add(0,1,1,1,1,0,1); add(0,1,0,2,2,0,1);
        add(0,1,1,1,2,0,1); add(0,1,1,1,3,0,1); add(0,1,0,2,3,1,1);
        add(0,0,1,1,2,0,1); add(0,0,1,1,2,0,1); add(0,0,0,2,2,0,1);
        add(0,0,1,1,1,0,1); add(0,0,1,1,1,0,1); add(0,0,0,2,1,0,1);
        add(0,0,1,1,0,0,1); add(0,0,1,1,0,0,1); add(0,0,0,2,0,0,1); add(0,0,0,0,0,0,0);
        // reset during HIGH, then a fresh tick
        add(0,1,1,1,0,0,1); add(1,0,0,0,0,0,0);
        add(0,1,1,1,0,0,1); add(0,0,1,1,0,0,1); add(0,0,0,2,0,0,1); add(0,0,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].tk);
            chk_all("vec", i, vecs[i].lvl, vecs[i].st, vecs[i].pend, vecs[i].drp, vecs[i].bsy);
        end

        // reset with a non-empty queue discards it and no pulse follows
        step(0,1); step(0,1); step(0,1); step(0,1);
        chk("pend_before_reset", 0, pending_o, 2);
        step(1,1);
        chk_all("reset_q", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0,0);
            chk_all("after_reset_q", i, 0, 0, 0, 0, 0);
        end

        // full queue plus a tick during reset: reset wins, no drop
        step(0,1); step(0,1); step(0,1); step(0,1); step(0,1);
        chk("pend_full", 0, pending_o, 3);
        step(1,1);
        chk_all("reset_full", 0, 0, 0, 0, 0, 0);

        // random ticks vs model, level looped through a rising-edge detector
        step(1,0);
        model_reset();
        rises = 0; dut_drops = 0; prev_lvl = 1'b0;
        for (int i = 0; i < 230; i++) begin
            logic t;
            t = (i < 200) ? (($urandom % 3) != 0) : 1'b0;
            step(0, t);
            model_step(t);
            chk_all("rand", i, m_lvl, m_st, 2'(m_pend), m_drp, m_bsy);
            if (level && !prev_lvl) rises++;
            if (dropped) dut_drops++;
            prev_lvl = level;
        end
        chk("rand_drops", 0, dut_drops, m_drops);
        chk("edge_count", 0, rises, m_ticks - dut_drops);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
